// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master engine among NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining APB_ARB_TIMEOUT_EN.
module apb_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [NUM_REQ-1:0]    i_req,
  input  logic [32*NUM_REQ-1:0] i_req_addr,
  input  logic [NUM_REQ-1:0]    i_req_write,
  input  logic [32*NUM_REQ-1:0] i_req_wdata,
  output logic [NUM_REQ-1:0]    o_grant,
  output logic [NUM_REQ-1:0]    o_req_done,
  output logic [31:0]           o_req_rdata,
  output logic                  o_req_slverr,
  output logic                  o_m_start,
  output logic [31:0]           o_m_addr,
  output logic                  o_m_write,
  output logic [31:0]           o_m_wdata,
  output logic                  o_m_abort,
  input  logic                  i_m_done,
  input  logic [31:0]           i_m_rdata,
  input  logic                  i_m_slverr,
  output logic [1:0]            o_dbg_state
);

  // Handshake: i_req is a level held until o_req_done; o_m_start is a single
  // pulse and the master answers with exactly one i_m_done pulse per start.

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [PW-1:0]        gidx_q, gidx_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 slverr_q, slverr_d;
  logic                 start_q, start_d;
  logic [31:0]          maddr_q, maddr_d;
  logic                 mwrite_q, mwrite_d;
  logic [31:0]          mwdata_q, mwdata_d;
`ifdef APB_ARB_TIMEOUT_EN
  logic [15:0]          cnt_q, cnt_d;
  logic                 abort_q, abort_d;
`endif

  logic [NUM_REQ-1:0]   elig;
  logic                 found;
  logic [PW-1:0]        sel;
  logic [PW-1:0]        cand;
  logic [31:0]          addr_arr  [NUM_REQ];
  logic [31:0]          wdata_arr [NUM_REQ];
  logic [PW-1:0]        ptr_next;

  // The requester just served is masked for its done cycle so it can drop i_req.
  always_comb begin
    elig  = i_req & ~done_q;
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i]  = i_req_addr[32*i +: 32];
      wdata_arr[i] = i_req_wdata[32*i +: 32];
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = PW'((int'(ptr_q) + i) % NUM_REQ);
      if (!found && elig[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  assign ptr_next = (gidx_q == PW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gidx_d   = gidx_q;
    grant_d  = grant_q;
    done_d   = '0;
    rdata_d  = rdata_q;
    slverr_d = slverr_q;
    start_d  = 1'b0;
    maddr_d  = maddr_q;
    mwrite_d = mwrite_q;
    mwdata_d = mwdata_q;
`ifdef APB_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    abort_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          gidx_d       = sel;
          grant_d      = '0;
          grant_d[sel] = 1'b1;
          maddr_d      = addr_arr[sel];
          mwrite_d     = i_req_write[sel];
          mwdata_d     = wdata_arr[sel];
          start_d      = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (i_m_done) begin
          rdata_d        = i_m_rdata;
          slverr_d       = i_m_slverr;
          done_d[gidx_q] = 1'b1;
          grant_d        = '0;
          ptr_d          = ptr_next;
          state_d        = IDLE;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          // Watchdog expiry completes the transaction as an error and resets the master.
          rdata_d        = '0;
          slverr_d       = 1'b1;
          abort_d        = 1'b1;
          done_d[gidx_q] = 1'b1;
          grant_d        = '0;
          ptr_d          = ptr_next;
          state_d        = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gidx_q   <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      rdata_q  <= '0;
      slverr_q <= 1'b0;
      start_q  <= 1'b0;
      maddr_q  <= '0;
      mwrite_q <= 1'b0;
      mwdata_q <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      abort_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gidx_q   <= gidx_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      slverr_q <= slverr_d;
      start_q  <= start_d;
      maddr_q  <= maddr_d;
      mwrite_q <= mwrite_d;
      mwdata_q <= mwdata_d;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      abort_q  <= abort_d;
`endif
    end
  end

  assign o_grant      = grant_q;
  assign o_req_done   = done_q;
  assign o_req_rdata  = rdata_q;
  assign o_req_slverr = slverr_q;
  assign o_m_start    = start_q;
  assign o_m_addr     = maddr_q;
  assign o_m_write    = mwrite_q;
  assign o_m_wdata    = mwdata_q;
  assign o_dbg_state  = state_q;
`ifdef APB_ARB_TIMEOUT_EN
  assign o_m_abort    = abort_q;
`else
  assign o_m_abort    = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter; the watchdog step runs only when
// APB_ARB_TIMEOUT_EN is defined.
module tb_apb_master_arbiter;

  localparam int N = 4;

  logic              clk;
  logic              i_reset;
  logic [N-1:0]      i_req;
  logic [32*N-1:0]   i_req_addr;
  logic [N-1:0]      i_req_write;
  logic [32*N-1:0]   i_req_wdata;
  logic [N-1:0]      o_grant;
  logic [N-1:0]      o_req_done;
  logic [31:0]       o_req_rdata;
  logic              o_req_slverr;
  logic              o_m_start;
  logic [31:0]       o_m_addr;
  logic              o_m_write;
  logic [31:0]       o_m_wdata;
  logic              o_m_abort;
  logic              i_m_done;
  logic [31:0]       i_m_rdata;
  logic              i_m_slverr;
  logic [1:0]        o_dbg_state;

  int checks = 0;
  int errors = 0;

  apb_master_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(8)) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_req        (i_req),
    .i_req_addr   (i_req_addr),
    .i_req_write  (i_req_write),
    .i_req_wdata  (i_req_wdata),
    .o_grant      (o_grant),
    .o_req_done   (o_req_done),
    .o_req_rdata  (o_req_rdata),
    .o_req_slverr (o_req_slverr),
    .o_m_start    (o_m_start),
    .o_m_addr     (o_m_addr),
    .o_m_write    (o_m_write),
    .o_m_wdata    (o_m_wdata),
    .o_m_abort    (o_m_abort),
    .i_m_done     (i_m_done),
    .i_m_rdata    (i_m_rdata),
    .i_m_slverr   (i_m_slverr),
    .o_dbg_state  (o_dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"},  32'(o_grant), 0);
    chk({tag, "_done"},   32'(o_req_done), 0);
    chk({tag, "_rdata"},  o_req_rdata, 0);
    chk({tag, "_slverr"}, 32'(o_req_slverr), 0);
    chk({tag, "_start"},  32'(o_m_start), 0);
    chk({tag, "_addr"},   o_m_addr, 0);
    chk({tag, "_write"},  32'(o_m_write), 0);
    chk({tag, "_wdata"},  o_m_wdata, 0);
    chk({tag, "_abort"},  32'(o_m_abort), 0);
    chk({tag, "_state"},  32'(o_dbg_state), 0);
  endtask

  task automatic set_req(input int k, input logic [31:0] addr, input logic wr, input logic [31:0] wd);
    i_req_addr[32*k +: 32]  = addr;
    i_req_write[k]          = wr;
    i_req_wdata[32*k +: 32] = wd;
  endtask

  // Called in an IDLE cycle with requests already applied; returns in the done cycle.
  task automatic txn(input string tag, input int idx, input logic [31:0] addr, input logic wr,
                     input logic [31:0] wd, input int lat, input logic [31:0] rd,
                     input logic err, input bit drop);
    logic [N-1:0] onehot;
    onehot = '0;
    onehot[idx] = 1'b1;
    tick();
    chk({tag, "_grant"}, 32'(o_grant), 32'(onehot));
    chk({tag, "_start"}, 32'(o_m_start), 1);
    chk({tag, "_addr"},  o_m_addr, addr);
    chk({tag, "_write"}, 32'(o_m_write), 32'(wr));
    chk({tag, "_wdata"}, o_m_wdata, wd);
    tick();
    chk({tag, "_start_once"}, 32'(o_m_start), 0);
    chk({tag, "_wait"},       32'(o_dbg_state), 2);
    if (drop) begin
      i_req[idx] = 1'b0;
      i_req_addr[32*idx +: 32] = 32'hBAD0_0000;
    end
    repeat (lat - 1) tick();
    chk({tag, "_grant_hold"}, 32'(o_grant), 32'(onehot));
    i_m_done   = 1'b1;
    i_m_rdata  = rd;
    i_m_slverr = err;
    tick();
    i_m_done   = 1'b0;
    i_m_slverr = 1'b0;
    chk({tag, "_done"},     32'(o_req_done), 32'(onehot));
    chk({tag, "_rdata"},    o_req_rdata, rd);
    chk({tag, "_slverr"},   32'(o_req_slverr), 32'(err));
    chk({tag, "_grant_clr"},32'(o_grant), 0);
    chk({tag, "_addr_hold"},o_m_addr, addr);
  endtask

  initial begin
    i_reset = 1'b1; i_req = '0; i_req_addr = '0; i_req_write = '0; i_req_wdata = '0;
    i_m_done = 1'b0; i_m_rdata = '0; i_m_slverr = 1'b0;
    tick(); tick();
    chk_all_zero("reset");
    i_reset = 1'b0;

    // Requester 2 reads 0x1000; master answers after 3 cycles.
    set_req(2, 32'h0000_1000, 1'b0, 32'h0);
    i_req = 4'b0100;
    txn("rd2", 2, 32'h0000_1000, 1'b0, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, 1'b0);
    i_req = '0;
    i_m_rdata = 32'h1234_5678;
    tick();
    chk("rd2_done_pulse", 32'(o_req_done), 0);
    chk("rd2_rdata_hold", o_req_rdata, 32'hDEAD_BEEF);

    // Stray master done in IDLE is ignored.
    i_m_done = 1'b1;
    tick();
    i_m_done = 1'b0;
    tick();
    chk("idle_done_ign", 32'(o_req_done), 0);
    chk("idle_rdata_ign", o_req_rdata, 32'hDEAD_BEEF);

    // ptr = 3 now: requester 3 beats requester 0, then 0 follows after one idle cycle.
    set_req(0, 32'h0000_0A00, 1'b0, 32'h0);
    set_req(3, 32'h0000_0D00, 1'b1, 32'h0000_00D3);
    i_req = 4'b1001;
    txn("bnd3", 3, 32'h0000_0D00, 1'b1, 32'h0000_00D3, 1, 32'h0000_0033, 1'b0, 1'b0);
    i_req = 4'b0001;
    txn("bnd0", 0, 32'h0000_0A00, 1'b0, 32'h0, 2, 32'h0000_0011, 1'b0, 1'b0);
    i_req = '0;

    // Requester 1 write with slave error.
    set_req(1, 32'h0000_0020, 1'b1, 32'h0000_0055);
    i_req = 4'b0010;
    txn("err1", 1, 32'h0000_0020, 1'b1, 32'h0000_0055, 2, 32'h0, 1'b1, 1'b0);
    i_req = '0;

    // Requester 2 drops its request and changes its address while in WAIT.
    set_req(2, 32'h0000_2200, 1'b0, 32'h0);
    i_req = 4'b0100;
    txn("drop2", 2, 32'h0000_2200, 1'b0, 32'h0, 2, 32'hCAFE_0002, 1'b0, 1'b1);
    tick();
    chk("drop2_no_regrant", 32'(o_grant), 0);

    // Reset in WAIT abandons the transaction with no done pulse.
    set_req(3, 32'h0000_3300, 1'b0, 32'h0);
    i_req = 4'b1000;
    tick();
    chk("rstw_grant", 32'(o_grant), 32'h8);
    tick();
    i_reset = 1'b1;
    i_req = '0;
    tick();
    i_reset = 1'b0;
    chk_all_zero("rst_wait");
    tick();
    chk("rst_wait_no_done", 32'(o_req_done), 0);

    // Fairness from ptr = 0: order 0,1,2,3,0 with one idle cycle between.
    for (int k = 0; k < N; k++) set_req(k, 32'h100 * k + 32'h10, k[0], 32'hA0 + k);
    i_req = 4'b1111;
    txn("rr0", 0, 32'h0000_0010, 1'b0, 32'h0000_00A0, 1, 32'h0000_0100, 1'b0, 1'b0);
    txn("rr1", 1, 32'h0000_0110, 1'b1, 32'h0000_00A1, 2, 32'h0000_0101, 1'b0, 1'b0);
    txn("rr2", 2, 32'h0000_0210, 1'b0, 32'h0000_00A2, 1, 32'h0000_0102, 1'b0, 1'b0);
    txn("rr3", 3, 32'h0000_0310, 1'b1, 32'h0000_00A3, 3, 32'h0000_0103, 1'b0, 1'b0);
    txn("rr0b", 0, 32'h0000_0010, 1'b0, 32'h0000_00A0, 1, 32'h0000_0104, 1'b0, 1'b0);
    i_req = '0;
    tick();
    chk("rr_end_grant", 32'(o_grant), 0);
    chk("rr_abort_zero", 32'(o_m_abort), 0);

`ifdef APB_ARB_TIMEOUT_EN
    // ptr = 1: requester 1 granted, master silent; expiry 8 cycles after WAIT entry.
    i_req = 4'b0011;
    tick();
    chk("to_grant", 32'(o_grant), 32'h2);
    tick();
    chk("to_wait", 32'(o_dbg_state), 2);
    for (int c = 0; c < 7; c++) begin
      tick();
      chk("to_no_done_early", 32'(o_req_done), 0);
    end
    tick();
    chk("to_done",   32'(o_req_done), 32'h2);
    chk("to_slverr", 32'(o_req_slverr), 1);
    chk("to_rdata",  o_req_rdata, 0);
    chk("to_abort",  32'(o_m_abort), 1);
    i_req = 4'b0001;
    tick();
    chk("to_abort_pulse", 32'(o_m_abort), 0);
    chk("to_next_grant",  32'(o_grant), 32'h1);
    i_req = '0;
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
